// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the execute-stage control logic.
//   exe_ctrl_state_e : execute-control sequencer states (2 bits, debug-visible)
//   OPCODE_LOAD      : major opcode of the LOAD instruction class
//   REG_ADDR_W       : register-file address width
package rv32i_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StLdStall = 2'd2,
    StMemWait = 2'd3
  } exe_ctrl_state_e;

endpackage

// File: rtl/rv32i_hazard_cmp.sv
// Combinational RAW compare between the decode instruction's sources and the
// ALU-stage destination. Shared by load-use detection and forwarding.
//   dec_ce, dec_rs1_addr, dec_rs2_addr : decode valid and source registers
//   alu_ce, alu_wr_rd, alu_rd_addr     : ALU valid, writes-rd, destination
//   hz1, hz2                           : rs1 / rs2 match a live non-x0 rd
module rv32i_hazard_cmp
  import rv32i_pkg::*;
(
  input  logic                  dec_ce,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  alu_ce,
  input  logic                  alu_wr_rd,
  input  logic [REG_ADDR_W-1:0] alu_rd_addr,
  output logic                  hz1,
  output logic                  hz2
);

  logic rd_live;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  assign rd_live = dec_ce & alu_ce & alu_wr_rd & (|alu_rd_addr);
  assign hz1     = rd_live & (dec_rs1_addr == alu_rd_addr);
  assign hz2     = rd_live & (dec_rs2_addr == alu_rd_addr);

endmodule

// File: rtl/rv32i_exe_ctrl.sv
// Execute-stage pipeline control sequencer.
// Inputs : i_clk, i_rst_n (sync, active low), decode/ALU instruction info,
//          i_change_pc (taken branch/jump), i_mem_stall, i_clr_timeout.
// Outputs: o_stall / o_force_stall / o_flush to the ALU and front end,
//          o_fwd_rs1 / o_fwd_rs2 forwarding enables, o_timeout sticky
//          memory-stall watchdog, o_state debug view of the FSM.
// Every output is a flop, so each reflects inputs sampled one edge earlier.
module rv32i_exe_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter int unsigned LD_STALL_CYCLES = 1,
  parameter int unsigned STALL_TIMEOUT   = 64,
  parameter int unsigned CNT_W           = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_dec_ce,
  input  logic [REG_ADDR_W-1:0] i_dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_dec_rs2_addr,
  input  logic                  i_alu_ce,
  input  logic                  i_alu_is_load,
  input  logic                  i_alu_wr_rd,
  input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
  input  logic                  i_alu_rd_valid,
  input  logic                  i_change_pc,
  input  logic                  i_mem_stall,
  input  logic                  i_clr_timeout,
  output logic                  o_stall,
  output logic                  o_force_stall,
  output logic                  o_flush,
  output logic                  o_fwd_rs1,
  output logic                  o_fwd_rs2,
  output logic                  o_timeout,
  output logic [1:0]            o_state
);

  localparam logic [CNT_W-1:0] FlushLoad  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LdLoad     = CNT_W'(LD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutMax = CNT_W'(STALL_TIMEOUT - 1);

  exe_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             hz1, hz2, ld_hz, wd_hit;
  logic             stall_q, force_q, flush_q, fwd1_q, fwd2_q, timeout_q;
  logic             stall_d, force_d, flush_d, fwd1_d, fwd2_d, timeout_d;

  rv32i_hazard_cmp u_hazard_cmp (
    .dec_ce       (i_dec_ce),
    .dec_rs1_addr (i_dec_rs1_addr),
    .dec_rs2_addr (i_dec_rs2_addr),
    .alu_ce       (i_alu_ce),
    .alu_wr_rd    (i_alu_wr_rd),
    .alu_rd_addr  (i_alu_rd_addr),
    .hz1          (hz1),
    .hz2          (hz2)
  );

  assign ld_hz = (hz1 | hz2) & i_alu_is_load;

  // Next state: a taken branch beats everything, then a memory stall, then
  // a load-use bubble (only entered from RUN).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_change_pc) begin
      state_d = StFlush;
      cnt_d   = FlushLoad;
    end else begin
      case (state_q)
        StRun: begin
          if (i_mem_stall) begin
            state_d = StMemWait;
          end else if (ld_hz) begin
            state_d = StLdStall;
            cnt_d   = LdLoad;
          end
        end
        StFlush: begin
          // The flush window is fixed length; a stall only decides where it ends.
          if (cnt_q == '0) begin
            state_d = i_mem_stall ? StMemWait : StRun;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StLdStall: begin
          // A memory stall already holds the pipe long enough to cover the load.
          if (i_mem_stall) begin
            state_d = StMemWait;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StMemWait: begin
          if (!i_mem_stall) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Output flops track the state being entered, so they line up with o_state.
  always_comb begin
    stall_d = (state_d == StMemWait);
    force_d = (state_d == StLdStall);
    flush_d = (state_d == StFlush);
    fwd1_d  = hz1 & ~i_alu_is_load & i_alu_rd_valid & (state_d != StFlush);
    fwd2_d  = hz2 & ~i_alu_is_load & i_alu_rd_valid & (state_d != StFlush);
  end

  // Watchdog: counts consecutive stall cycles, saturating at the trip point.
  always_comb begin
    wd_hit = (wcnt_q == TimeoutMax);
    if (!i_mem_stall) begin
      wcnt_d = '0;
    end else if (wd_hit) begin
      wcnt_d = wcnt_q;
    end else begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
    // Set has priority over a coincident clear.
    timeout_d = (i_mem_stall & wd_hit) | (timeout_q & ~i_clr_timeout);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      stall_q   <= 1'b0;
      force_q   <= 1'b0;
      flush_q   <= 1'b0;
      fwd1_q    <= 1'b0;
      fwd2_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      stall_q   <= stall_d;
      force_q   <= force_d;
      flush_q   <= flush_d;
      fwd1_q    <= fwd1_d;
      fwd2_q    <= fwd2_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_stall       = stall_q;
  assign o_force_stall = force_q;
  assign o_flush       = flush_q;
  assign o_fwd_rs1     = fwd1_q;
  assign o_fwd_rs2     = fwd2_q;
  assign o_timeout     = timeout_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_rv32i_exe_ctrl.sv
// Directed bench for rv32i_exe_ctrl. Each step pushes the outputs expected
// after the next rising edge into a scoreboard queue; the edge handler pops
// and compares them against the DUT.
module tb_rv32i_exe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_ce, alu_ce, is_load, wr_rd, rd_valid, change_pc, mem_stall, clr;
  logic [4:0] rs1, rs2, rd;
  logic       stall, force_stall, flush, fwd1, fwd2, timeout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rv32i_exe_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dec_ce       (dec_ce),
    .i_dec_rs1_addr (rs1),
    .i_dec_rs2_addr (rs2),
    .i_alu_ce       (alu_ce),
    .i_alu_is_load  (is_load),
    .i_alu_wr_rd    (wr_rd),
    .i_alu_rd_addr  (rd),
    .i_alu_rd_valid (rd_valid),
    .i_change_pc    (change_pc),
    .i_mem_stall    (mem_stall),
    .i_clr_timeout  (clr),
    .o_stall        (stall),
    .o_force_stall  (force_stall),
    .o_flush        (flush),
    .o_fwd_rs1      (fwd1),
    .o_fwd_rs2      (fwd2),
    .o_timeout      (timeout),
    .o_state        (state)
  );

  task automatic idle();
    dec_ce = 0; rs1 = 0; rs2 = 0; alu_ce = 0; is_load = 0; wr_rd = 0;
    rd = 0; rd_valid = 0; change_pc = 0; mem_stall = 0; clr = 0;
  endtask

  task automatic set_alu(input logic ld, input logic [4:0] dst, input logic vld);
    alu_ce = 1; wr_rd = 1; is_load = ld; rd = dst; rd_valid = vld;
  endtask

  task automatic set_dec(input logic [4:0] a, input logic [4:0] b);
    dec_ce = 1; rs1 = a; rs2 = b;
  endtask

  // Expected order: stall, force_stall, flush, fwd_rs1, fwd_rs2, timeout, state.
  task automatic push(input string tag, input logic s, input logic fs, input logic fl,
                      input logic f1, input logic f2, input logic to, input logic [1:0] st);
    tag_q.push_back(tag);
    exp_q.push_back({s, fs, fl, f1, f2, to, st});
  endtask

  task automatic tick();
    logic [7:0] obs;
    logic [7:0] exp;
    string      tag;
    @(posedge clk);
    #1;
    obs = {stall, force_stall, flush, fwd1, fwd2, timeout, state};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b required=<entry>", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 0;
    idle();
    push("reset", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    rst_n = 1;
    push("idle", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Load-use on rs1: exactly one bubble, no forwarding from a load.
    set_alu(1, 5'd5, 1); set_dec(5'd5, 5'd0);
    push("ld_use", 0, 1, 0, 0, 0, 0, 2'd2); tick();
    idle();
    push("ld_use_end", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    push("ld_use_run", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Forwarding from a non-load.
    set_alu(0, 5'd7, 1); set_dec(5'd3, 5'd7);
    push("fwd_rs2", 0, 0, 0, 0, 1, 0, 2'd0); tick();
    set_alu(0, 5'd0, 1); set_dec(5'd3, 5'd0);
    push("fwd_x0", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    set_alu(0, 5'd9, 1); set_dec(5'd9, 5'd9);
    push("fwd_both", 0, 0, 0, 1, 1, 0, 2'd0); tick();
    set_alu(0, 5'd9, 0);
    push("fwd_not_valid", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    idle();

    // Branch: two flush cycles; forwarding suppressed mid-flush.
    change_pc = 1;
    push("br_flush1", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    change_pc = 0; set_alu(0, 5'd7, 1); set_dec(5'd7, 5'd7);
    push("br_flush2", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    idle();
    push("br_done", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Branch preempts a load-use bubble.
    set_alu(1, 5'd5, 1); set_dec(5'd0, 5'd5);
    push("ld_rs2", 0, 1, 0, 0, 0, 0, 2'd2); tick();
    idle(); change_pc = 1;
    push("ld_preempt", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    change_pc = 0;
    push("ld_pre_fl2", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    push("ld_pre_done", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Short memory stall: no timeout.
    mem_stall = 1;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("mem10_%0d", i), 1, 0, 0, 0, 0, 0, 2'd3); tick();
    end
    mem_stall = 0;
    push("mem10_rel", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // 64-cycle stall trips the watchdog on the last edge; it stays sticky.
    mem_stall = 1;
    for (int i = 0; i < 64; i++) begin
      push($sformatf("mem64_%0d", i), 1, 0, 0, 0, 0, (i == 63), 2'd3); tick();
    end
    mem_stall = 0;
    push("to_sticky1", 0, 0, 0, 0, 0, 1, 2'd0); tick();
    push("to_sticky2", 0, 0, 0, 0, 0, 1, 2'd0); tick();
    clr = 1;
    push("to_clear", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Clear held throughout: set still wins, and the saturated counter keeps
    // re-asserting while the stall persists.
    mem_stall = 1;
    for (int i = 0; i < 66; i++) begin
      push($sformatf("to_setwin_%0d", i), 1, 0, 0, 0, 0, (i >= 63), 2'd3); tick();
    end
    mem_stall = 0;
    push("to_setwin_clr", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    clr = 0;

    // Reset on the second flush cycle aborts the window.
    change_pc = 1;
    push("rst_fl1", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    change_pc = 0; rst_n = 0;
    push("rst_mid_flush", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    rst_n = 1;
    push("rst_after1", 0, 0, 0, 0, 0, 0, 2'd0); tick();
    push("rst_after2", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    // Branch, stall and load-use together: flush first, then memory wait.
    set_alu(1, 5'd4, 1); set_dec(5'd4, 5'd0); change_pc = 1; mem_stall = 1;
    push("sim_flush1", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    idle(); mem_stall = 1;
    push("sim_flush2", 0, 0, 1, 0, 0, 0, 2'd1); tick();
    push("sim_memwait", 1, 0, 0, 0, 0, 0, 2'd3); tick();
    mem_stall = 0;
    push("sim_done", 0, 0, 0, 0, 0, 0, 2'd0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_exe_ctrl.md
Name: rv32i_exe_ctrl

Overview:
- Pipeline-control sequencer for the RV32I execute stage.
- Generates the ALU stage's stall, force-stall and flush controls, plus the front-end flush.
- Detects load-use hazards between decode and the ALU stage, and produces rs1/rs2 forwarding enables.
- Sequences multi-cycle flush and stall windows with a small FSM, and watchdogs memory-stage stalls.

Parameters:
- FLUSH_CYCLES, 2: cycles o_flush is held after a taken branch or jump.
- LD_STALL_CYCLES, 1: bubble cycles inserted for a load-use hazard.
- STALL_TIMEOUT, 64: consecutive i_mem_stall cycles before o_timeout sets.
- CNT_W, 7: width of the internal counters; must satisfy 2^CNT_W > max(FLUSH_CYCLES, LD_STALL_CYCLES, STALL_TIMEOUT).

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_dec_ce  in  1  the decode stage holds a valid instruction.
- i_dec_rs1_addr  in  5  source register 1 of the decode instruction.
- i_dec_rs2_addr  in  5  source register 2 of the decode instruction.
- i_alu_ce  in  1  the ALU stage holds a valid instruction.
- i_alu_is_load  in  1  the ALU-stage opcode is LOAD.
- i_alu_wr_rd  in  1  the ALU-stage instruction writes rd.
- i_alu_rd_addr  in  5  the ALU-stage destination register.
- i_alu_rd_valid  in  1  the ALU rd value is final.
- i_change_pc  in  1  the ALU resolved a taken branch or jump.
- i_mem_stall  in  1  the memory stage requests a stall.
- i_clr_timeout  in  1  clears o_timeout.
- o_stall  out  1  drives the ALU stall input.
- o_force_stall  out  1  drives the ALU force-stall input.
- o_flush  out  1  drives the ALU flush input and the fetch/decode flush.
- o_fwd_rs1  out  1  forward the ALU rd value to decode rs1.
- o_fwd_rs2  out  1  forward the ALU rd value to decode rs2.
- o_timeout  out  1  sticky memory-stall watchdog flag.
- o_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state=RUN and all counters=0.
  - o_stall, o_force_stall, o_flush, o_fwd_rs1, o_fwd_rs2 and o_timeout are all 0.
  - o_state=RUN.
  - Reset mid-FLUSH or mid-LD_STALL aborts the window immediately.
- All outputs are registered: an input event is reflected at the edge after it is sampled (1-cycle latency).
- States: RUN=0, FLUSH=1, LD_STALL=2, MEM_WAIT=3.
- Definitions:
  - hz1 = i_dec_ce & i_alu_ce & i_alu_wr_rd & (i_alu_rd_addr!=0) & (i_dec_rs1_addr==i_alu_rd_addr). hz2 is the same check on rs2.
  - ld_hz = (hz1|hz2) & i_alu_is_load.
- Transition priority at each edge, highest first:
  1. i_change_pc: go to FLUSH and load cnt=FLUSH_CYCLES-1. This applies from any state; it preempts LD_STALL and MEM_WAIT.
  2. i_mem_stall: go to MEM_WAIT. This applies from RUN or LD_STALL. The LD_STALL count is dropped, because the stall covers the hazard.
  3. ld_hz, in RUN only: go to LD_STALL with cnt=LD_STALL_CYCLES-1.
- Per-state behaviour:
  - FLUSH: o_flush=1; cnt decrements each cycle. At cnt==0, next state is MEM_WAIT if i_mem_stall, else RUN. i_mem_stall does not shorten or extend the flush.
  - LD_STALL: o_force_stall=1; cnt decrements; at 0, next state is RUN. A new ld_hz re-evaluates in RUN.
  - MEM_WAIT: o_stall=1 while i_mem_stall=1. When i_mem_stall=0, next state is RUN.
  - Outside these states, each of o_stall, o_force_stall and o_flush is 0.
- Forwarding:
  - o_fwd_rs1 = hz1 & ~i_alu_is_load & i_alu_rd_valid. o_fwd_rs2 is the same with hz2.
  - Both are registered and forced to 0 while in FLUSH.
  - rd=x0 never forwards.
- Watchdog:
  - wcnt increments on each cycle with i_mem_stall=1 and clears on i_mem_stall=0.
  - When wcnt reaches STALL_TIMEOUT-1, o_timeout is set at the next edge. wcnt saturates and does not wrap.
  - o_timeout is cleared only by reset or i_clr_timeout. If set and clear coincide, set wins.
- Widths: counters are CNT_W bits unsigned. Address compares are 5-bit equality.

Decomposition:
- rv32i_pkg (shared) holds:
  - the exe_ctrl_state_e typedef (RUN/FLUSH/LD_STALL/MEM_WAIT, 2 bits);
  - the LOAD opcode constant;
  - REG_ADDR_W=5.
- One sub-module, rv32i_hazard_cmp: purely combinational. It computes hz1 and hz2 and is reused for forwarding and ld_hz.

Test Plan:
- Load-use: ALU holds a load with rd=5; decode has rs1=5 with i_dec_ce=1 -> o_force_stall=1 for exactly 1 cycle, o_state=2 then 0, o_fwd_rs1=0.
- Forward: ALU holds ADD with rd=7 and rd_valid=1; decode has rs2=7 -> o_fwd_rs2=1 next cycle, no stall. Same with rd=0 -> o_fwd_rs2=0.
- Branch: 1-cycle i_change_pc pulse -> o_flush=1 for 2 cycles, then 0. i_change_pc during LD_STALL -> o_force_stall drops and o_flush rises at the same edge.
- Mem stall: i_mem_stall held 10 cycles -> o_stall=1 for 10 cycles (lagging by 1), o_timeout stays 0. Held 64 cycles -> o_timeout=1, sticky after release, cleared by i_clr_timeout.
- Reset mid-flush: i_rst_n=0 on the second FLUSH cycle -> at that edge every output is 0 and o_state=0. No flush continues after reset releases.
- Simultaneous events: i_change_pc=1, i_mem_stall=1 and ld_hz all in RUN -> o_state=FLUSH. After 2 cycles with i_mem_stall still 1 -> MEM_WAIT with o_stall=1.
